// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, reads instruction words over a req/ack handshake and
// presents the latest word to the control unit, with redirect, flush and timeout.
module instr_fetch_unit #(
  parameter int                    ADDR_WIDTH = 26,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 26'h0001000,
  parameter int                    MAX_WAIT   = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  FETCH_REQ,
  input  logic                  PC_LOAD,
  input  logic [ADDR_WIDTH-1:0] PC_IN,
  output logic                  MEM_READ,
  output logic [ADDR_WIDTH-1:0] MEM_ADDR,
  input  logic [DATA_WIDTH-1:0] MEM_DATA_IN,
  input  logic                  MEM_ACK,
  output logic [DATA_WIDTH-1:0] INSTRUCTION,
  output logic                  INSTR_VALID,
  output logic [ADDR_WIDTH-1:0] INSTR_PC,
  output logic [ADDR_WIDTH-1:0] PC_OUT,
  output logic                  FETCH_ERR
);

  localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic                    mem_read_q, mem_read_d;
  logic [DATA_WIDTH-1:0]   instr_q, instr_d;
  logic                    valid_q, valid_d;
  logic [ADDR_WIDTH-1:0]   instr_pc_q, instr_pc_d;
  logic                    err_q, err_d;
  logic                    flush_q, flush_d;
  logic [WAIT_W-1:0]       wait_q, wait_d;
  logic                    timeout;

  // Timeout fires on the last permitted REQ cycle that passes without an ack.
  assign timeout = (MAX_WAIT != 0) && (wait_q == WAIT_W'(MAX_WAIT - 1));

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    mem_addr_d = mem_addr_q;
    mem_read_d = mem_read_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    instr_pc_d = instr_pc_q;
    err_d      = err_q;
    flush_d    = flush_q;
    wait_d     = wait_q;

    case (state_q)
      IDLE, HOLD: begin
        if (PC_LOAD) begin
          pc_d    = PC_IN;
          err_d   = 1'b0;
          valid_d = 1'b0;
        end
        if (FETCH_REQ) begin
          state_d    = REQ;
          mem_read_d = 1'b1;
          mem_addr_d = PC_LOAD ? PC_IN : pc_q;
          valid_d    = 1'b0;
          wait_d     = '0;
        end
      end

      REQ: begin
        if (MEM_ACK) begin
          mem_read_d = 1'b0;
          flush_d    = 1'b0;
          if (PC_LOAD || flush_q) begin
            // Word belongs to the pre-redirect stream: drop it.
            state_d = IDLE;
            if (PC_LOAD) begin
              pc_d  = PC_IN;
              err_d = 1'b0;
            end
          end else begin
            state_d    = HOLD;
            instr_d    = MEM_DATA_IN;
            instr_pc_d = mem_addr_q;
            valid_d    = 1'b1;
            pc_d       = pc_q + ADDR_WIDTH'(1);
          end
        end else begin
          wait_d = wait_q + WAIT_W'(1);
          if (PC_LOAD) begin
            pc_d    = PC_IN;
            err_d   = 1'b0;
            flush_d = 1'b1;
          end
          if (timeout) begin
            state_d    = IDLE;
            err_d      = 1'b1;
            mem_read_d = 1'b0;
            valid_d    = 1'b0;
            flush_d    = 1'b0;
          end
        end
      end

      default: begin
        state_d    = IDLE;
        mem_read_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      mem_addr_q <= RESET_PC;
      mem_read_q <= 1'b0;
      instr_q    <= '0;
      valid_q    <= 1'b0;
      instr_pc_q <= '0;
      err_q      <= 1'b0;
      flush_q    <= 1'b0;
      wait_q     <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      mem_addr_q <= mem_addr_d;
      mem_read_q <= mem_read_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
      instr_pc_q <= instr_pc_d;
      err_q      <= err_d;
      flush_q    <= flush_d;
      wait_q     <= wait_d;
    end
  end

  assign MEM_READ    = mem_read_q;
  assign MEM_ADDR    = mem_addr_q;
  assign INSTRUCTION = instr_q;
  assign INSTR_VALID = valid_q;
  assign INSTR_PC    = instr_pc_q;
  assign PC_OUT      = pc_q;
  assign FETCH_ERR   = err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: each task drives one scenario and checks
// registered outputs 1 time unit after the rising edge.
module tb_instr_fetch_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        FETCH_REQ = 1'b0;
  logic        PC_LOAD = 1'b0;
  logic [25:0] PC_IN = '0;
  logic        MEM_READ;
  logic [25:0] MEM_ADDR;
  logic [31:0] MEM_DATA_IN = '0;
  logic        MEM_ACK = 1'b0;
  logic [31:0] INSTRUCTION;
  logic        INSTR_VALID;
  logic [25:0] INSTR_PC;
  logic [25:0] PC_OUT;
  logic        FETCH_ERR;

  int checks = 0;
  int errors = 0;

  instr_fetch_unit #(
    .ADDR_WIDTH(26), .DATA_WIDTH(32), .RESET_PC(26'h0001000), .MAX_WAIT(16)
  ) dut (
    .CLK(CLK), .RST(RST), .FETCH_REQ(FETCH_REQ), .PC_LOAD(PC_LOAD), .PC_IN(PC_IN),
    .MEM_READ(MEM_READ), .MEM_ADDR(MEM_ADDR), .MEM_DATA_IN(MEM_DATA_IN), .MEM_ACK(MEM_ACK),
    .INSTRUCTION(INSTRUCTION), .INSTR_VALID(INSTR_VALID), .INSTR_PC(INSTR_PC),
    .PC_OUT(PC_OUT), .FETCH_ERR(FETCH_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; step(); step(); RST = 1'b0;
    checks++; if (MEM_READ !== 1'b0) begin errors++; $display("FAIL reset_mem_read got=%0b exp=0", MEM_READ); end
    checks++; if (MEM_ADDR !== 26'h0001000) begin errors++; $display("FAIL reset_mem_addr got=%h exp=0001000", MEM_ADDR); end
    checks++; if (PC_OUT !== 26'h0001000) begin errors++; $display("FAIL reset_pc got=%h exp=0001000", PC_OUT); end
    checks++; if (INSTRUCTION !== 32'h0) begin errors++; $display("FAIL reset_instr got=%h exp=0", INSTRUCTION); end
    checks++; if (INSTR_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", INSTR_VALID); end
    checks++; if (INSTR_PC !== 26'h0) begin errors++; $display("FAIL reset_instr_pc got=%h exp=0", INSTR_PC); end
    checks++; if (FETCH_ERR !== 1'b0) begin errors++; $display("FAIL reset_err got=%0b exp=0", FETCH_ERR); end
    $display("reset: PC_OUT=%h MEM_ADDR=%h", PC_OUT, MEM_ADDR);
  endtask

  task automatic test_basic_fetch();
    FETCH_REQ = 1'b1; step(); FETCH_REQ = 1'b0;
    checks++; if (MEM_READ !== 1'b1) begin errors++; $display("FAIL basic_read got=%0b exp=1", MEM_READ); end
    checks++; if (MEM_ADDR !== 26'h0001000) begin errors++; $display("FAIL basic_addr got=%h exp=0001000", MEM_ADDR); end
    MEM_ACK = 1'b1; MEM_DATA_IN = 32'h20010005; step(); MEM_ACK = 1'b0;
    checks++; if (MEM_READ !== 1'b0) begin errors++; $display("FAIL basic_read_drop got=%0b exp=0", MEM_READ); end
    checks++; if (INSTRUCTION !== 32'h20010005) begin errors++; $display("FAIL basic_instr got=%h exp=20010005", INSTRUCTION); end
    checks++; if (INSTR_VALID !== 1'b1) begin errors++; $display("FAIL basic_valid got=%0b exp=1", INSTR_VALID); end
    checks++; if (INSTR_PC !== 26'h0001000) begin errors++; $display("FAIL basic_instr_pc got=%h exp=0001000", INSTR_PC); end
    checks++; if (PC_OUT !== 26'h0001001) begin errors++; $display("FAIL basic_pc got=%h exp=0001001", PC_OUT); end
    $display("basic fetch: INSTRUCTION=%h INSTR_PC=%h PC_OUT=%h", INSTRUCTION, INSTR_PC, PC_OUT);
  endtask

  task automatic test_delayed_ack();
    FETCH_REQ = 1'b1; step(); FETCH_REQ = 1'b0;
    checks++; if (INSTR_VALID !== 1'b0) begin errors++; $display("FAIL delay_valid_clr got=%0b exp=0", INSTR_VALID); end
    checks++; if (INSTRUCTION !== 32'h20010005) begin errors++; $display("FAIL delay_instr_kept got=%h exp=20010005", INSTRUCTION); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (MEM_READ !== 1'b1 || MEM_ADDR !== 26'h0001001) begin errors++; $display("FAIL delay_stable cyc=%0d read=%0b addr=%h exp read=1 addr=0001001", i, MEM_READ, MEM_ADDR); end
      step();
    end
    checks++; if (INSTR_VALID !== 1'b0) begin errors++; $display("FAIL delay_valid_early got=%0b exp=0", INSTR_VALID); end
    MEM_ACK = 1'b1; MEM_DATA_IN = 32'h12345678; step(); MEM_ACK = 1'b0;
    checks++; if (INSTR_VALID !== 1'b1 || INSTRUCTION !== 32'h12345678) begin errors++; $display("FAIL delay_capture valid=%0b instr=%h exp valid=1 instr=12345678", INSTR_VALID, INSTRUCTION); end
    checks++; if (PC_OUT !== 26'h0001002) begin errors++; $display("FAIL delay_pc got=%h exp=0001002", PC_OUT); end
    checks++; if (FETCH_ERR !== 1'b0) begin errors++; $display("FAIL delay_err got=%0b exp=0", FETCH_ERR); end
    $display("delayed ack: INSTRUCTION=%h PC_OUT=%h", INSTRUCTION, PC_OUT);
  endtask

  task automatic test_redirect();
    FETCH_REQ = 1'b1; step(); FETCH_REQ = 1'b0;
    step(); step();
    PC_LOAD = 1'b1; PC_IN = 26'h0002000; step(); PC_LOAD = 1'b0;
    checks++; if (PC_OUT !== 26'h0002000) begin errors++; $display("FAIL redir_pc got=%h exp=0002000", PC_OUT); end
    checks++; if (MEM_READ !== 1'b1 || MEM_ADDR !== 26'h0001002) begin errors++; $display("FAIL redir_hold read=%0b addr=%h exp read=1 addr=0001002", MEM_READ, MEM_ADDR); end
    MEM_ACK = 1'b1; MEM_DATA_IN = 32'hDEADBEEF; step(); MEM_ACK = 1'b0;
    checks++; if (INSTR_VALID !== 1'b0) begin errors++; $display("FAIL redir_valid got=%0b exp=0", INSTR_VALID); end
    checks++; if (INSTRUCTION !== 32'h12345678) begin errors++; $display("FAIL redir_instr got=%h exp=12345678", INSTRUCTION); end
    checks++; if (PC_OUT !== 26'h0002000 || MEM_READ !== 1'b0) begin errors++; $display("FAIL redir_after pc=%h read=%0b exp pc=0002000 read=0", PC_OUT, MEM_READ); end
    FETCH_REQ = 1'b1; step(); FETCH_REQ = 1'b0;
    checks++; if (MEM_ADDR !== 26'h0002000 || MEM_READ !== 1'b1) begin errors++; $display("FAIL redir_refetch addr=%h read=%0b exp addr=0002000 read=1", MEM_ADDR, MEM_READ); end
    MEM_ACK = 1'b1; MEM_DATA_IN = 32'hAAAA5555; step(); MEM_ACK = 1'b0;
    checks++; if (INSTR_PC !== 26'h0002000 || PC_OUT !== 26'h0002001 || INSTR_VALID !== 1'b1) begin errors++; $display("FAIL redir_capture ipc=%h pc=%h valid=%0b exp ipc=0002000 pc=0002001 valid=1", INSTR_PC, PC_OUT, INSTR_VALID); end
    $display("redirect: PC_OUT=%h INSTR_PC=%h INSTRUCTION=%h", PC_OUT, INSTR_PC, INSTRUCTION);
  endtask

  task automatic test_timeout();
    FETCH_REQ = 1'b1; step(); FETCH_REQ = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checks++; if (MEM_READ !== 1'b1 || FETCH_ERR !== 1'b0) begin errors++; $display("FAIL tmo_wait cyc=%0d read=%0b err=%0b exp read=1 err=0", i, MEM_READ, FETCH_ERR); end
      step();
    end
    checks++; if (FETCH_ERR !== 1'b1) begin errors++; $display("FAIL tmo_err got=%0b exp=1", FETCH_ERR); end
    checks++; if (MEM_READ !== 1'b0) begin errors++; $display("FAIL tmo_read got=%0b exp=0", MEM_READ); end
    checks++; if (PC_OUT !== 26'h0002001 || INSTR_VALID !== 1'b0) begin errors++; $display("FAIL tmo_pc pc=%h valid=%0b exp pc=0002001 valid=0", PC_OUT, INSTR_VALID); end
    MEM_ACK = 1'b1; MEM_DATA_IN = 32'h55555555; step(); MEM_ACK = 1'b0;
    checks++; if (INSTR_VALID !== 1'b0 || INSTRUCTION !== 32'hAAAA5555 || PC_OUT !== 26'h0002001) begin errors++; $display("FAIL tmo_late_ack valid=%0b instr=%h pc=%h exp valid=0 instr=aaaa5555 pc=0002001", INSTR_VALID, INSTRUCTION, PC_OUT); end
    PC_LOAD = 1'b1; PC_IN = 26'h3FFFFFF; step(); PC_LOAD = 1'b0;
    checks++; if (FETCH_ERR !== 1'b0 || PC_OUT !== 26'h3FFFFFF) begin errors++; $display("FAIL tmo_clear err=%0b pc=%h exp err=0 pc=3ffffff", FETCH_ERR, PC_OUT); end
    $display("timeout: FETCH_ERR=%0b PC_OUT=%h", FETCH_ERR, PC_OUT);
  endtask

  task automatic test_wrap();
    FETCH_REQ = 1'b1; step(); FETCH_REQ = 1'b0;
    checks++; if (MEM_ADDR !== 26'h3FFFFFF) begin errors++; $display("FAIL wrap_addr got=%h exp=3ffffff", MEM_ADDR); end
    MEM_ACK = 1'b1; MEM_DATA_IN = 32'h0BADF00D; step(); MEM_ACK = 1'b0;
    checks++; if (INSTR_PC !== 26'h3FFFFFF) begin errors++; $display("FAIL wrap_instr_pc got=%h exp=3ffffff", INSTR_PC); end
    checks++; if (PC_OUT !== 26'h0000000) begin errors++; $display("FAIL wrap_pc got=%h exp=0000000", PC_OUT); end
    $display("wrap: INSTR_PC=%h PC_OUT=%h", INSTR_PC, PC_OUT);
  endtask

  task automatic test_load_corners();
    PC_LOAD = 1'b1; PC_IN = 26'h0000123; FETCH_REQ = 1'b1; step(); PC_LOAD = 1'b0; FETCH_REQ = 1'b0;
    checks++; if (MEM_ADDR !== 26'h0000123 || PC_OUT !== 26'h0000123 || MEM_READ !== 1'b1) begin errors++; $display("FAIL load_fetch addr=%h pc=%h read=%0b exp addr=0000123 pc=0000123 read=1", MEM_ADDR, PC_OUT, MEM_READ); end
    PC_LOAD = 1'b1; PC_IN = 26'h0000456; MEM_ACK = 1'b1; MEM_DATA_IN = 32'h11111111; step();
    PC_LOAD = 1'b0; MEM_ACK = 1'b0;
    checks++; if (INSTR_VALID !== 1'b0 || PC_OUT !== 26'h0000456 || MEM_READ !== 1'b0 || INSTRUCTION !== 32'h0BADF00D) begin errors++; $display("FAIL load_ack valid=%0b pc=%h read=%0b instr=%h exp valid=0 pc=0000456 read=0 instr=0badf00d", INSTR_VALID, PC_OUT, MEM_READ, INSTRUCTION); end
    FETCH_REQ = 1'b1; step(); FETCH_REQ = 1'b0;
    MEM_ACK = 1'b1; MEM_DATA_IN = 32'h22222222; step(); MEM_ACK = 1'b0;
    checks++; if (INSTR_VALID !== 1'b1 || INSTR_PC !== 26'h0000456 || PC_OUT !== 26'h0000457) begin errors++; $display("FAIL load_refetch valid=%0b ipc=%h pc=%h exp valid=1 ipc=0000456 pc=0000457", INSTR_VALID, INSTR_PC, PC_OUT); end
    PC_LOAD = 1'b1; PC_IN = 26'h0000789; step(); PC_LOAD = 1'b0;
    checks++; if (INSTR_VALID !== 1'b0 || PC_OUT !== 26'h0000789 || INSTRUCTION !== 32'h22222222) begin errors++; $display("FAIL load_hold valid=%0b pc=%h instr=%h exp valid=0 pc=0000789 instr=22222222", INSTR_VALID, PC_OUT, INSTRUCTION); end
    $display("load corners: PC_OUT=%h INSTR_VALID=%0b", PC_OUT, INSTR_VALID);
  endtask

  task automatic test_reset_mid_req();
    FETCH_REQ = 1'b1; step(); FETCH_REQ = 1'b0;
    RST = 1'b1; step(); RST = 1'b0;
    checks++; if (MEM_READ !== 1'b0) begin errors++; $display("FAIL rstreq_read got=%0b exp=0", MEM_READ); end
    MEM_ACK = 1'b1; MEM_DATA_IN = 32'h33333333; step(); MEM_ACK = 1'b0;
    checks++; if (INSTRUCTION !== 32'h0 || INSTR_VALID !== 1'b0 || INSTR_PC !== 26'h0) begin errors++; $display("FAIL rstreq_instr instr=%h valid=%0b ipc=%h exp instr=0 valid=0 ipc=0", INSTRUCTION, INSTR_VALID, INSTR_PC); end
    checks++; if (PC_OUT !== 26'h0001000 || MEM_ADDR !== 26'h0001000 || FETCH_ERR !== 1'b0 || MEM_READ !== 1'b0) begin errors++; $display("FAIL rstreq_state pc=%h addr=%h err=%0b read=%0b exp pc=0001000 addr=0001000 err=0 read=0", PC_OUT, MEM_ADDR, FETCH_ERR, MEM_READ); end
    $display("reset mid-req: PC_OUT=%h INSTR_VALID=%0b", PC_OUT, INSTR_VALID);
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_delayed_ack();
    test_redirect();
    test_timeout();
    test_wrap();
    test_load_corners();
    test_reset_mid_req();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage sitting directly upstream of the processor control unit.
- Owns the program counter and issues word reads to instruction memory over a req/ack handshake.
- Latches the returned word into an instruction register whose output drives the control unit's INSTRUCTION input.
- Supports PC redirect (branch/jump), discard of in-flight reads after a redirect, and a memory-timeout error flag.

Parameters:
- ADDR_WIDTH, 26, width of PC and memory word address.
- DATA_WIDTH, 32, instruction/memory data width.
- RESET_PC, 26'h0001000, PC value after reset.
- MAX_WAIT, 16, max cycles in REQ without ack before timeout; 0 disables timeout.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- FETCH_REQ  in  1  control unit requests the next instruction (pulse or level; sampled only in IDLE/HOLD).
- PC_LOAD  in  1  redirect strobe.
- PC_IN  in  ADDR_WIDTH  redirect target.
- MEM_READ  out  1  memory read request.
- MEM_ADDR  out  ADDR_WIDTH  memory word address.
- MEM_DATA_IN  in  DATA_WIDTH  read data, valid when MEM_ACK=1.
- MEM_ACK  in  1  read completion, 1-cycle pulse.
- INSTRUCTION  out  DATA_WIDTH  instruction register to control unit.
- INSTR_VALID  out  1  INSTRUCTION holds a freshly fetched word.
- INSTR_PC  out  ADDR_WIDTH  address INSTRUCTION was fetched from.
- PC_OUT  out  ADDR_WIDTH  current PC (next fetch address).
- FETCH_ERR  out  1  sticky timeout flag.

Behaviour:
- Reset, sampled at the CLK edge:
  - PC=RESET_PC; MEM_ADDR=RESET_PC.
  - MEM_READ=0, INSTRUCTION=0, INSTR_VALID=0, INSTR_PC=0, FETCH_ERR=0.
  - Wait counter=0, flush flag=0, state=IDLE.
  - RST mid-REQ aborts the read: MEM_READ=0 next cycle, and any later MEM_ACK is ignored while in IDLE.
- States are IDLE, REQ and HOLD. All outputs are registered.
- IDLE/HOLD with FETCH_REQ=1:
  - Next cycle MEM_READ=1, MEM_ADDR=PC, INSTR_VALID=0, wait counter=0, state=REQ.
  - INSTRUCTION keeps its old value.
- REQ:
  - MEM_READ and MEM_ADDR are held stable until MEM_ACK.
  - FETCH_REQ is ignored in this state.
- REQ with MEM_ACK=1 and no flush:
  - INSTRUCTION=MEM_DATA_IN, INSTR_PC=MEM_ADDR, INSTR_VALID=1, MEM_READ=0.
  - PC=PC+1 modulo 2^ADDR_WIDTH (all-ones wraps to 0).
  - State=HOLD. Minimum fetch latency is 2 cycles from FETCH_REQ to INSTR_VALID (ack in first REQ cycle).
- REQ with no ack:
  - Counter increments.
  - If MAX_WAIT!=0 and counter==MAX_WAIT-1 without ack: FETCH_ERR=1, MEM_READ=0, INSTR_VALID=0, state=IDLE, PC unchanged.
  - A late ack arriving in IDLE is ignored.
- HOLD: INSTRUCTION and INSTR_VALID are held until the next FETCH_REQ.
- PC_LOAD is accepted in any state and has priority over increment: PC=PC_IN, FETCH_ERR cleared.
  - In IDLE/HOLD with simultaneous FETCH_REQ: the read is issued at PC_IN (MEM_ADDR=PC_IN), and PC=PC_IN.
  - In REQ: the read completes at the old address but the flush flag is set. On ack the data is discarded, INSTR_VALID stays 0, PC is not incremented, MEM_READ=0, state=IDLE, flush cleared.
  - PC_LOAD coinciding with MEM_ACK in REQ: data discarded, PC=PC_IN, state=IDLE.
  - PC_LOAD in HOLD: INSTR_VALID=0 (the held instruction is stale).
- FETCH_ERR is cleared only by RST or PC_LOAD. While FETCH_ERR=1, FETCH_REQ is still honoured.

Test Plan:
- Reset then FETCH_REQ, memory acks 1 cycle later with 32'h20010005 -> MEM_ADDR=26'h0001000 with MEM_READ=1 for 1 cycle; then INSTRUCTION=32'h20010005, INSTR_VALID=1, INSTR_PC=26'h0001000, PC_OUT=26'h0001001.
- Ack delayed 5 cycles -> MEM_READ and MEM_ADDR stable for all 5 cycles; INSTR_VALID rises the cycle after ack; no FETCH_ERR.
- Redirect: PC_LOAD=1, PC_IN=26'h0002000 asserted 2 cycles into REQ; ack with 32'hDEADBEEF -> INSTR_VALID stays 0, INSTRUCTION unchanged, PC_OUT=26'h0002000. Next FETCH_REQ reads 26'h0002000.
- Timeout with MAX_WAIT=16, no ack -> after 16 REQ cycles FETCH_ERR=1, MEM_READ=0, PC unchanged. A later PC_LOAD clears FETCH_ERR.
- Wrap: PC_LOAD 26'h3FFFFFF, fetch with ack -> INSTR_PC=26'h3FFFFFF, PC_OUT=0.
- RST asserted during REQ with ack arriving 1 cycle later -> all outputs at reset values, ack ignored, PC=26'h0001000.
